// File: rtl/adc_block_averager_if.sv
// ---------------------------------------------------------------------------
// adc_block_averager_if
//
// Purpose: ready/valid link between the ADC conversion FSM (reached over
// GPIO) and the block averager. Carries one sample per four-phase handshake.
//
// Signals:
//   adc_conv_valid  master -> slave  sample valid (asynchronous to slave clk)
//   adc_data        master -> slave  sample, stable while valid is high and
//                                    until adc_conv_ready falls
//   adc_conv_ready  slave  -> master high = slave can accept a sample
// ---------------------------------------------------------------------------
interface adc_block_averager_if #(
    parameter int DATA_W = 12
);
    logic              adc_conv_valid;
    logic [DATA_W-1:0] adc_data;
    logic              adc_conv_ready;

    modport master (
        output adc_conv_valid,
        output adc_data,
        input  adc_conv_ready
    );

    modport slave (
        input  adc_conv_valid,
        input  adc_data,
        output adc_conv_ready
    );
endinterface

// File: rtl/adc_block_averager.sv
// ---------------------------------------------------------------------------
// adc_block_averager
//
// Purpose: captures one ADC sample per four-phase handshake, averages blocks
// of 2^LOG2_N samples and shows each new average on a thermometer LED bar.
//
// Ports:
//   clk        in   main clock
//   reset      in   synchronous, active-low reset
//   adc        slave modport of adc_block_averager_if (valid/data in,
//              registered ready out)
//   avg_valid  out  one-cycle pulse when avg_data has just been updated
//   avg_data   out  latest block average, held until the next block ends
//   led_out    out  thermometer display of avg_data, one cycle after avg_valid
// ---------------------------------------------------------------------------
module adc_block_averager #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 3,
    parameter int LED_W  = 10
) (
    input  logic                clk,
    input  logic                reset,
    adc_block_averager_if.slave adc,
    output logic                avg_valid,
    output logic [DATA_W-1:0]   avg_data,
    output logic [LED_W-1:0]    led_out
);

    // Accumulator is wide enough for 2^LOG2_N full-scale samples.
    localparam int ACC_W  = DATA_W + LOG2_N;
    // Lit-segment count spans 0..LED_W.
    localparam int LIT_W  = $clog2(LED_W + 1);
    localparam int PROD_W = DATA_W + LIT_W;
    localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                valid_meta_q, valid_s_q;
    logic                capture;
    logic                block_done;

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    sum;
    logic [LOG2_N-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   avg_data_q, avg_data_d;
    logic                avg_valid_q, avg_valid_d;

    logic [PROD_W-1:0]   prod;
    logic [LIT_W-1:0]    lit;
    logic [LED_W-1:0]    thermo;
    logic [LED_W-1:0]    led_q, led_d;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer for the GPIO valid. Data is not synchronized: the
    // protocol keeps it stable from valid rise until ready falls, which is
    // well after valid_s has settled.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_meta_q <= 1'b0;
            valid_s_q    <= 1'b0;
        end else begin
            valid_meta_q <= adc.adc_conv_valid;
            valid_s_q    <= valid_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // A sample is taken only when ready is already visible to the master, so
    // the first edge after reset (ready still 0) never captures.
    assign capture = (state_q == ST_IDLE) && ready_q && valid_s_q;

    // -----------------------------------------------------------------------
    // Handshake FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture)    state_d = ST_ACK;
            ST_ACK:  if (!valid_s_q) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Handshake FSM: registered output. Ready drops on the capture edge and
    // only rises again one edge after returning to IDLE, which is what limits
    // a held-high valid to a single capture.
    // -----------------------------------------------------------------------
    always_comb begin
        ready_d = 1'b0;
        if (state_q == ST_IDLE && !capture) begin
            ready_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Accumulator / sample counter / average
    // -----------------------------------------------------------------------
    assign sum        = acc_q + ACC_W'(adc.adc_data);
    assign block_done = capture && (cnt_q == CNT_LAST);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_data_d  = avg_data_q;
        avg_valid_d = 1'b0;
        if (block_done) begin
            // Divide by 2^LOG2_N by dropping the low bits (truncation).
            avg_data_d  = sum[ACC_W-1:LOG2_N];
            avg_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
        end else if (capture) begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_data_q  <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_data_q  <= avg_data_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // LED bar: scale the average onto 0..LED_W lit segments, then expand to a
    // thermometer code. Updated from the freshly registered average, so it
    // lands one cycle after avg_valid.
    // -----------------------------------------------------------------------
    assign prod = PROD_W'(avg_data_q) * PROD_W'(LED_W + 1);
    assign lit  = prod[PROD_W-1:DATA_W];

    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_thermo
            assign thermo[gi] = (lit > LIT_W'(gi));
        end
    endgenerate

    always_comb begin
        led_d = led_q;
        if (avg_valid_q) begin
            led_d = thermo;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign adc.adc_conv_ready = ready_q;
    assign avg_valid          = avg_valid_q;
    assign avg_data           = avg_data_q;
    assign led_out            = led_q;

endmodule

// File: tb/tb_adc_block_averager.sv
// ---------------------------------------------------------------------------
// tb_adc_block_averager
//
// Drives four-phase handshakes into adc_block_averager and checks the block
// averages and LED bar against a reference model that keeps the samples of
// the current block in a queue and averages them with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_adc_block_averager;

    localparam int DATA_W = 12;
    localparam int LOG2_N = 3;
    localparam int LED_W  = 10;
    localparam int N      = 1 << LOG2_N;
    localparam int BOUND  = 200;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              avg_valid;
    logic [DATA_W-1:0] avg_data;
    logic [LED_W-1:0]  led_out;

    adc_block_averager_if #(.DATA_W(DATA_W)) bus ();

    adc_block_averager #(
        .DATA_W(DATA_W),
        .LOG2_N(LOG2_N),
        .LED_W (LED_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .adc      (bus),
        .avg_valid(avg_valid),
        .avg_data (avg_data),
        .led_out  (led_out)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int model_pend[$];
    int exp_avg_q[$];

    // Observations collected by the monitor
    logic [DATA_W-1:0] obs_avg_q[$];
    logic [LED_W-1:0]  obs_led_q[$];
    int   long_pulse_cnt = 0;
    int   ready_fall_cnt = 0;
    logic prev_avg_valid = 1'b0;
    logic prev_ready     = 1'b0;

    always @(negedge clk) begin
        if (prev_avg_valid === 1'b1) obs_led_q.push_back(led_out);
        if (avg_valid === 1'b1) begin
            obs_avg_q.push_back(avg_data);
            if (prev_avg_valid === 1'b1) long_pulse_cnt++;
        end
        if (prev_ready === 1'b1 && bus.adc_conv_ready === 1'b0) ready_fall_cnt++;
        prev_avg_valid = avg_valid;
        prev_ready     = bus.adc_conv_ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_push(input int d);
        int s;
        model_pend.push_back(d);
        if (model_pend.size() == N) begin
            s = 0;
            foreach (model_pend[k]) s += model_pend[k];
            exp_avg_q.push_back(s / N);
            model_pend.delete();
        end
    endfunction

    function automatic int model_led(input int avg);
        int lit;
        lit = (avg * (LED_W + 1)) / (1 << DATA_W);
        return (1 << lit) - 1;
    endfunction

    task automatic clear_obs();
        obs_avg_q.delete();
        obs_led_q.delete();
        exp_avg_q.delete();
    endtask

    // One four-phase handshake. lat = negedges from valid rise to ready low,
    // or -1 if a bound expired.
    task automatic do_sample(input int d, output int lat);
        int t;
        t = 0;
        while (bus.adc_conv_ready !== 1'b1 && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (t >= BOUND) begin
            lat = -1;
            return;
        end
        bus.adc_data       = d[DATA_W-1:0];
        bus.adc_conv_valid = 1'b1;
        t = 0;
        while (bus.adc_conv_ready !== 1'b0 && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        lat = (t >= BOUND) ? -1 : t;
        bus.adc_conv_valid = 1'b0;
        model_push(d);
    endtask

    // Drives s[first..N-1] and checks the resulting block against the model
    // (and against plan constants when want_avg >= 0).
    task automatic test_block(input string name, input int s[N], input int first,
                              input int want_avg, input int want_led);
        int lat, maxlat, timeouts, lp0, e;
        logic [DATA_W-1:0] e_avg;
        logic [LED_W-1:0]  e_led;
        maxlat = 0; timeouts = 0; lp0 = long_pulse_cnt;
        for (int i = first; i < N; i++) begin
            do_sample(s[i], lat);
            if (lat < 0) timeouts++;
            else if (lat > maxlat) maxlat = lat;
        end
        repeat (4) @(negedge clk);
        total++;
        if (timeouts != 0 || maxlat > 3 || maxlat < 1)
            begin bad++; $display("FAIL %s latency: got max=%0d timeouts=%0d want 1..3 and 0", name, maxlat, timeouts); end
        total++;
        if (obs_avg_q.size() != 1 || exp_avg_q.size() != 1) begin
            bad++;
            $display("FAIL %s pulse_count: got=%0d want=%0d", name, obs_avg_q.size(), exp_avg_q.size());
        end else begin
            e = exp_avg_q[0];
            e_avg = e[DATA_W-1:0];
            e_led = LED_W'(model_led(e));
            total++;
            if (obs_avg_q[0] !== e_avg)
                begin bad++; $display("FAIL %s avg_data: got=%h want=%h", name, obs_avg_q[0], e_avg); end
            if (want_avg >= 0) begin
                total++;
                if (obs_avg_q[0] !== want_avg[DATA_W-1:0])
                    begin bad++; $display("FAIL %s avg_plan: got=%h want=%h", name, obs_avg_q[0], want_avg[DATA_W-1:0]); end
                total++;
                if (obs_led_q.size() < 1 || obs_led_q[0] !== want_led[LED_W-1:0])
                    begin bad++; $display("FAIL %s led_plan: got=%h want=%h", name, (obs_led_q.size() > 0) ? obs_led_q[0] : 'x, want_led[LED_W-1:0]); end
            end
            total++;
            if (obs_led_q.size() < 1 || obs_led_q[0] !== e_led)
                begin bad++; $display("FAIL %s led_out: got=%h want=%h", name, (obs_led_q.size() > 0) ? obs_led_q[0] : 'x, e_led); end
            repeat (10) @(negedge clk);
            total++;
            if (avg_data !== e_avg)
                begin bad++; $display("FAIL %s avg_hold: got=%h want=%h", name, avg_data, e_avg); end
        end
        total++;
        if (long_pulse_cnt != lp0)
            begin bad++; $display("FAIL %s avg_valid_width: got=%0d extra cycles want=0", name, long_pulse_cnt - lp0); end
        $display("block %s: avg=%h led=%h", name, avg_data, led_out);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        bus.adc_conv_valid = 1'b0;
        bus.adc_data = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.adc_conv_ready !== 1'b0) begin bad++; $display("FAIL reset ready: got=%b want=0", bus.adc_conv_ready); end
        total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL reset avg_valid: got=%b want=0", avg_valid); end
        total++; if (avg_data !== '0) begin bad++; $display("FAIL reset avg_data: got=%h want=000", avg_data); end
        total++; if (led_out !== '0) begin bad++; $display("FAIL reset led_out: got=%h want=000", led_out); end
        reset = 1'b1;
        model_pend.delete();
        @(negedge clk);
        total++; if (bus.adc_conv_ready !== 1'b1) begin bad++; $display("FAIL reset ready_rise: got=%b want=1", bus.adc_conv_ready); end
        $display("reset: ready=%b avg=%h led=%h", bus.adc_conv_ready, avg_data, led_out);
    endtask

    task automatic test_plan_blocks();
        int blk[N];
        clear_obs();
        foreach (blk[i]) blk[i] = 'h800;
        test_block("midscale", blk, 0, 'h800, 'h01F);
        clear_obs();
        foreach (blk[i]) blk[i] = i;
        test_block("truncation", blk, 0, 'h003, 'h000);
        clear_obs();
        foreach (blk[i]) blk[i] = 'hFFF;
        test_block("full_scale", blk, 0, 'hFFF, 'h3FF);
    endtask

    task automatic test_held_valid();
        int blk[N];
        int f0, hi_after, t, d;
        bit fell;
        clear_obs();
        foreach (blk[i]) blk[i] = $urandom_range(0, (1 << DATA_W) - 1);
        d = blk[0];
        t = 0;
        while (bus.adc_conv_ready !== 1'b1 && t < BOUND) begin @(negedge clk); t++; end
        f0 = ready_fall_cnt; hi_after = 0; fell = 0;
        bus.adc_data = d[DATA_W-1:0];
        bus.adc_conv_valid = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (fell && bus.adc_conv_ready !== 1'b0) hi_after++;
            if (bus.adc_conv_ready === 1'b0) fell = 1;
        end
        total++;
        if (ready_fall_cnt - f0 != 1) begin bad++; $display("FAIL held captures: got=%0d want=1", ready_fall_cnt - f0); end
        total++;
        if (hi_after != 0) begin bad++; $display("FAIL held ready_low: got=%0d high cycles want=0", hi_after); end
        bus.adc_conv_valid = 1'b0;
        model_push(d);
        t = 0;
        while (bus.adc_conv_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        total++;
        if (t > 4) begin bad++; $display("FAIL held ready_return: got=%0d cycles want<=4", t); end
        $display("held_valid: captures=%0d ready_return=%0d", ready_fall_cnt - f0, t);
        test_block("held_valid", blk, 1, -1, 0);
    endtask

    task automatic test_reset_mid_block();
        int blk[N];
        int lat;
        clear_obs();
        for (int i = 0; i < 5; i++) do_sample('h100, lat);
        repeat (4) @(negedge clk);
        total++;
        if (obs_avg_q.size() != 0) begin bad++; $display("FAIL midreset early_pulse: got=%0d want=0", obs_avg_q.size()); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_pend.delete();
        clear_obs();
        foreach (blk[i]) blk[i] = 'h200;
        test_block("after_reset", blk, 0, 'h200, 'h001);
    endtask

    task automatic test_valid_during_reset();
        int blk[N];
        int t, d;
        clear_obs();
        foreach (blk[i]) blk[i] = $urandom_range(0, (1 << DATA_W) - 1);
        d = blk[0];
        reset = 1'b0;
        bus.adc_data = d[DATA_W-1:0];
        bus.adc_conv_valid = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_pend.delete();
        @(negedge clk);
        t = 0;
        while (bus.adc_conv_ready !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        total++;
        if (t >= 20) begin bad++; $display("FAIL valid_in_reset capture: got=none want=capture"); end
        bus.adc_conv_valid = 1'b0;
        model_push(d);
        $display("valid_in_reset: capture after %0d cycles", t);
        test_block("valid_in_reset", blk, 1, -1, 0);
    endtask

    task automatic test_random_blocks();
        int blk[N];
        for (int b = 0; b < 3; b++) begin
            clear_obs();
            foreach (blk[i]) blk[i] = $urandom_range(0, (1 << DATA_W) - 1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            test_block("random", blk, 0, -1, 0);
        end
    endtask

    initial begin
        bus.adc_conv_valid = 1'b0;
        bus.adc_data = '0;
        @(negedge clk);
        test_reset();
        test_plan_blocks();
        test_held_valid();
        test_reset_mid_block();
        test_valid_during_reset();
        test_random_blocks();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
